// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Groups the datapath memory port (ADR/WD/RD plus MemWrite strobe) with the
//   responder's handshake outputs.
//   master : datapath side, drives req/we/adr/wd, observes rd/ready/err/busy
//   slave  : memory side, the mirror image
interface mem_responder_if;
  logic        req;    // request valid, sampled only while the responder is idle
  logic        we;     // 1 = write, 0 = read
  logic [31:0] adr;    // byte address
  logic [31:0] wd;     // write data
  logic [31:0] rd;     // read data, valid while ready=1
  logic        ready;  // one-cycle completion pulse
  logic        err;    // misaligned / out-of-range qualifier, valid while ready=1
  logic        busy;   // access in flight, new requests not accepted

  modport master (output req, we, adr, wd, input rd, ready, err, busy);
  modport slave  (input req, we, adr, wd, output rd, ready, err, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Unified instruction/data memory for a multicycle MIPS32 datapath. A request
//   accepted in IDLE completes LATENCY cycles later with a single-cycle ready
//   pulse; misaligned or out-of-range accesses complete with err=1, rd=0 and
//   no memory write. The array is not reset, so its contents survive reset.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_responder_if.slave (req/we/adr/wd in, rd/ready/err/busy out)
// Parameters
//   DEPTH   : number of 32-bit words, power of two, >= 4
//   LATENCY : cycles from accept edge to ready pulse, >= 1
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  // Wait counter only has to hold LATENCY-2
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT  = (LATENCY >= 2) ? CW'(LATENCY - 2) : {CW{1'b0}};
  localparam logic [31:0]   ADR_LIMIT = 32'(4 * DEPTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] RESP = 2'b10;
  // With a single-cycle latency the accept edge is also the edge entering RESP
  localparam logic [1:0] ACCEPT_STATE = (LATENCY == 1) ? RESP : WAIT;

  logic [31:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          we_q,    we_d;
  logic [31:0]   adr_q,   adr_d;
  logic [31:0]   wd_q,    wd_d;
  logic [31:0]   rd_q,    rd_d;
  logic          ready_q, ready_d;
  logic          err_q,   err_d;
  logic          busy_q,  busy_d;

  logic          acc_we_s;
  logic [31:0]   acc_adr_s;
  logic [31:0]   acc_wd_s;
  logic [AW-1:0] acc_idx_s;
  logic          acc_err_s;
  logic          enter_resp_s;
  logic          mem_wr_s;

  // Select the access being completed: live inputs when the accept edge is
  // also the completion edge (LATENCY=1), captured copies otherwise.
  always_comb begin
    acc_we_s  = we_q;
    acc_adr_s = adr_q;
    acc_wd_s  = wd_q;
    if (state_q == IDLE) begin
      acc_we_s  = bus.we;
      acc_adr_s = bus.adr;
      acc_wd_s  = bus.wd;
    end else begin
      acc_we_s  = we_q;
      acc_adr_s = adr_q;
      acc_wd_s  = wd_q;
    end
  end

  assign acc_idx_s = acc_adr_s[AW+1:2];
  assign acc_err_s = (acc_adr_s[1:0] != 2'b00) || (acc_adr_s >= ADR_LIMIT);

  // FSM next state, wait counter and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = ACCEPT_STATE;
          cnt_d   = CNT_INIT;
          we_d    = bus.we;
          adr_d   = bus.adr;
          wd_d    = bus.wd;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);
  assign mem_wr_s     = enter_resp_s && acc_we_s && !acc_err_s;

  // Registered response: rd updates only on reads, errors force zero
  always_comb begin
    ready_d = enter_resp_s;
    err_d   = enter_resp_s && acc_err_s;
    busy_d  = (state_d != IDLE);
    rd_d    = rd_q;
    if (enter_resp_s) begin
      if (acc_err_s) begin
        rd_d = 32'h0000_0000;
      end else if (acc_we_s) begin
        rd_d = rd_q;
      end else begin
        rd_d = mem[acc_idx_s];
      end
    end else begin
      rd_d = rd_q;
    end
  end

  // Control and output registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      we_q    <= 1'b0;
      adr_q   <= 32'h0000_0000;
      wd_q    <= 32'h0000_0000;
      rd_q    <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Memory array write; gated by reset so an access cannot land while reset is held
  always_ff @(posedge clk) begin
    if (reset && mem_wr_s) begin
      mem[acc_idx_s] <= acc_wd_s;
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Randomized self-checking bench for mem_responder. Two instances are used:
//   LATENCY=2 and LATENCY=1. A word-array model per instance predicts rd, err
//   and completion latency from the address rules.
module tb_mem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int passes = 0;

  // model[0] belongs to the LATENCY=1 instance, model[1] to LATENCY=2
  logic [31:0] model   [2][DEPTH];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int lat, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (lat == 2) begin
      bus2.req = r; bus2.we = w; bus2.adr = a; bus2.wd = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.adr = a; bus1.wd = d;
    end
  endtask

  task automatic sample(input int lat, output logic r, output logic e,
                        output logic b, output logic [31:0] v);
    if (lat == 2) begin
      r = bus2.ready; e = bus2.err; b = bus2.busy; v = bus2.rd;
    end else begin
      r = bus1.ready; e = bus1.err; b = bus1.busy; v = bus1.rd;
    end
  endtask

  // One complete access on the chosen instance, with inputs scrambled while busy
  task automatic access(input int lat, input logic w, input logic [31:0] a, input logic [31:0] d);
    int li;
    int n;
    bit seen;
    logic exp_err;
    logic [31:0] exp_rd;
    logic r, e, b;
    logic [31:0] v;
    li = lat - 1;
    exp_err = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    if (exp_err) exp_rd = 32'h0000_0000;
    else if (w) exp_rd = last_rd[li];
    else exp_rd = model[li][int'(a[9:2])];

    @(negedge clk);
    drive(lat, 1'b1, w, a, d);
    @(posedge clk); #1;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 8) begin
      sample(lat, r, e, b, v);
      if (r) begin
        seen = 1'b1;
      end else begin
        check("busy_in_flight", 32'(b), 32'd1);
        check("err_without_ready", 32'(e), 32'd0);
        drive(lat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        @(posedge clk); #1;
        n++;
      end
    end
    check("ready_latency", 32'(n), 32'(lat));
    check("ready_busy", 32'(b), 32'd1);
    check("ready_err", 32'(e), 32'(exp_err));
    check("ready_rd", v, exp_rd);

    @(negedge clk);
    drive(lat, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    @(posedge clk); #1;
    sample(lat, r, e, b, v);
    check("pulse_single", 32'(r), 32'd0);
    check("idle_busy", 32'(b), 32'd0);
    check("idle_err", 32'(e), 32'd0);
    check("rd_held", v, exp_rd);

    if (!exp_err && w) model[li][int'(a[9:2])] = d;
    last_rd[li] = exp_rd;
  endtask

  initial begin
    logic r, e, b;
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] acc_adr;
    int lat, sel, widx;

    // Reset held three cycles
    reset = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drive(1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    for (int l = 1; l <= 2; l++) begin
      sample(l, r, e, b, v);
      check("rst_rd", v, 32'h0000_0000);
      check("rst_ready", 32'(r), 32'd0);
      check("rst_err", 32'(e), 32'd0);
      check("rst_busy", 32'(b), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_rd[0] = 32'h0000_0000;
    last_rd[1] = 32'h0000_0000;
    repeat (3) begin
      @(posedge clk); #1;
      for (int l = 1; l <= 2; l++) begin
        sample(l, r, e, b, v);
        check("idle_no_ready", 32'(r), 32'd0);
        check("idle_not_busy", 32'(b), 32'd0);
      end
    end

    // Write then read back at LATENCY=2
    access(2, 1'b1, 32'h0000_0010, 32'hCAFE_BABE);
    access(2, 1'b0, 32'h0000_0010, $urandom);

    // LATENCY=1: load word 0 then read it back
    access(1, 1'b1, 32'h0000_0000, 32'h8C01_0004);
    access(1, 1'b0, 32'h0000_0000, $urandom);

    // Error cases, misaligned write suppressed, last valid word boundary
    access(2, 1'b0, 32'h0000_0013, $urandom);
    access(2, 1'b0, 32'(4 * DEPTH), $urandom);
    access(2, 1'b1, 32'h0000_0011, 32'hDEAD_BEEF);
    access(2, 1'b1, 32'(4 * DEPTH), 32'h0BAD_0BAD);
    access(2, 1'b0, 32'h0000_0010, $urandom);
    access(2, 1'b1, 32'(4 * DEPTH - 4), 32'h5555_AAAA);
    access(2, 1'b0, 32'(4 * DEPTH - 4), $urandom);
    access(1, 1'b0, 32'h0000_0002, $urandom);

    // Prefill the low 16 words of both instances
    for (int i = 0; i < 16; i++) begin
      access(2, 1'b1, 32'(i * 4), $urandom);
      access(1, 1'b1, 32'(i * 4), $urandom);
    end

    // req held high with adr toggling every cycle on the LATENCY=2 instance
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(2, 1'b1, 1'b0, ((k % 2) == 1) ? 32'h0000_0004 : 32'h0000_0000, $urandom);
      @(posedge clk); #1;
      sample(2, r, e, b, v);
      check("hold_ready", 32'(r), ((k % 3) == 1) ? 32'd1 : 32'd0);
      if ((k % 3) == 1) begin
        acc_adr = (((k - 1) % 2) == 1) ? 32'h0000_0004 : 32'h0000_0000;
        check("hold_rd", v, model[1][int'(acc_adr[9:2])]);
        check("hold_err", 32'(e), 32'd0);
        last_rd[1] = model[1][int'(acc_adr[9:2])];
      end
    end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    @(posedge clk); #1;

    // Reset during WAIT aborts a write
    access(2, 1'b1, 32'h0000_0020, 32'hA5A5_0020);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #1;
    sample(2, r, e, b, v);
    check("abort_busy_before", 32'(b), 32'd1);
    #2 reset = 1'b0;
    #1;
    sample(2, r, e, b, v);
    check("abort_busy", 32'(b), 32'd0);
    check("abort_ready", 32'(r), 32'd0);
    check("abort_rd", v, 32'h0000_0000);
    drive(2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    repeat (2) begin
      @(posedge clk); #1;
      sample(2, r, e, b, v);
      check("abort_no_ready", 32'(r), 32'd0);
      check("abort_idle", 32'(b), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    last_rd[0] = 32'h0000_0000;
    last_rd[1] = 32'h0000_0000;
    @(posedge clk); #1;
    access(2, 1'b0, 32'h0000_0020, $urandom);

    // Randomized mix of reads, writes, misaligned and out-of-range accesses
    for (int t = 0; t < 40; t++) begin
      lat  = ((t % 2) == 1) ? 1 : 2;
      sel  = $urandom_range(0, 9);
      widx = $urandom_range(0, 15);
      if (sel < 6) a = 32'(widx * 4);
      else if (sel < 8) a = 32'(widx * 4 + $urandom_range(1, 3));
      else a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
      access(lat, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
